// File: rtl/i2c_passthru_bitrx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | i2c_passthru_bitrx: captures one I2C bit period (init/mid-change/final SDA) |
// | with setup-time and double-toggle checks. Glitch filter: define            |
// | I2C_PASSTHRU_BITRX_GLITCH_FILTER_EN.                          Rev 1.0       |
// +----------------------------------------------------------------------------+
module i2c_passthru_bitrx #(
  parameter int F_REF_T_SU_DAT      = 2,
  parameter int WIDTH_F_REF_SU_DAT  = 2,
  parameter int F_REF_T_SPIKE       = 1,
  parameter int WIDTH_F_REF_T_SPIKE = 1
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_f_ref,
  input  logic i_scl,
  input  logic i_sda,
  input  logic i_start_rx,
  output logic o_rx_sda_init_valid,
  output logic o_rx_sda_init,
  output logic o_rx_sda_mid_change,
  output logic o_rx_sda_final,
  output logic o_rx_done,
  output logic o_violation
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_LOW  = 3'd1;
  localparam logic [2:0] ST_SCL0      = 3'd2;
  localparam logic [2:0] ST_SCL1      = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;
  localparam logic [2:0] ST_VIOLATION = 3'd5;

  localparam logic [WIDTH_F_REF_SU_DAT-1:0] c_su_reload = WIDTH_F_REF_SU_DAT'(F_REF_T_SU_DAT);
  localparam logic [WIDTH_F_REF_SU_DAT-1:0] c_su_one    = WIDTH_F_REF_SU_DAT'(1);

  if ((F_REF_T_SU_DAT >= (1 << WIDTH_F_REF_SU_DAT)) || (F_REF_T_SPIKE < 1) ||
      (F_REF_T_SPIKE >= (1 << WIDTH_F_REF_T_SPIKE))) begin : g_param_chk
    $error("i2c_passthru_bitrx: counter width too small for timing parameter");
  end

  logic [1:0] r_pad_meta;
  logic [1:0] r_pad_sync;
  logic       r_fref_meta;
  logic       r_fref_sync;
  logic       r_fref_prev;
  logic       w_fref_rise;
  logic       w_scl_f;
  logic       w_sda_f;
  logic       r_sda_q;
  logic       w_sda_chg;
  logic [WIDTH_F_REF_SU_DAT-1:0] r_su_timer;
  logic [2:0] r_state;
  logic       r_init_valid;
  logic       r_init;
  logic       r_mid;
  logic       r_final;
  logic       r_done;
  logic       r_violation;

  // Bit 0 is SCL, bit 1 is SDA; synchronizers idle high like the bus.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_pad_meta  <= 2'b11;
      r_pad_sync  <= 2'b11;
      r_fref_meta <= 1'b0;
      r_fref_sync <= 1'b0;
      r_fref_prev <= 1'b0;
    end else begin
      r_pad_meta  <= {i_sda, i_scl};
      r_pad_sync  <= r_pad_meta;
      r_fref_meta <= i_f_ref;
      r_fref_sync <= r_fref_meta;
      r_fref_prev <= r_fref_sync;
    end
  end

  assign w_fref_rise = r_fref_sync & ~r_fref_prev;

`ifdef I2C_PASSTHRU_BITRX_GLITCH_FILTER_EN
  localparam logic [WIDTH_F_REF_T_SPIKE-1:0] c_spike_lim = WIDTH_F_REF_T_SPIKE'(F_REF_T_SPIKE);
  localparam logic [WIDTH_F_REF_T_SPIKE-1:0] c_spike_one = WIDTH_F_REF_T_SPIKE'(1);

  for (genvar k = 0; k < 2; k++) begin : g_filt
    logic                           r_filt;
    logic [WIDTH_F_REF_T_SPIKE-1:0] r_cnt;
    logic [WIDTH_F_REF_T_SPIKE-1:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + c_spike_one;

    // Count f_ref edges the new level has survived; any reversion restarts.
    always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
        r_filt <= 1'b1;
        r_cnt  <= '0;
      end else if (r_pad_sync[k] == r_filt) begin
        r_cnt <= '0;
      end else if (w_fref_rise) begin
        if (w_cnt_inc >= c_spike_lim) begin
          r_filt <= r_pad_sync[k];
          r_cnt  <= '0;
        end else begin
          r_cnt <= w_cnt_inc;
        end
      end
    end
  end

  assign w_scl_f = g_filt[0].r_filt;
  assign w_sda_f = g_filt[1].r_filt;
`else
  assign w_scl_f = r_pad_sync[0];
  assign w_sda_f = r_pad_sync[1];
`endif

  assign w_sda_chg = w_sda_f ^ r_sda_q;

  // Setup timer: reload wins over a coincident f_ref decrement.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_sda_q    <= 1'b1;
      r_su_timer <= '0;
    end else begin
      r_sda_q <= w_sda_f;
      if (w_sda_chg) begin
        r_su_timer <= c_su_reload;
      end else if (w_fref_rise && (r_su_timer != '0)) begin
        r_su_timer <= r_su_timer - c_su_one;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state      <= ST_IDLE;
      r_init_valid <= 1'b0;
      r_init       <= 1'b1;
      r_mid        <= 1'b0;
      r_final      <= 1'b1;
      r_done       <= 1'b0;
      r_violation  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_VIOLATION: begin
          // A new capture starts from a clean status, including after a violation.
          if (i_start_rx) begin
            r_init_valid <= 1'b0;
            r_mid        <= 1'b0;
            r_done       <= 1'b0;
            r_violation  <= 1'b0;
            r_state      <= ST_WAIT_LOW;
          end
        end
        ST_WAIT_LOW: begin
          if (!w_scl_f) r_state <= ST_SCL0;
        end
        ST_SCL0: begin
          if (w_scl_f) begin
            if (r_su_timer != '0) begin
              r_violation <= 1'b1;
              r_done      <= 1'b1;
              r_state     <= ST_VIOLATION;
            end else begin
              r_init       <= w_sda_f;
              r_final      <= w_sda_f;
              r_init_valid <= 1'b1;
              r_state      <= ST_SCL1;
            end
          end
        end
        ST_SCL1: begin
          // SCL fall masks an SDA change in the same cycle.
          if (!w_scl_f) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else if (w_sda_chg) begin
            if (r_mid) begin
              r_violation <= 1'b1;
              r_done      <= 1'b1;
              r_state     <= ST_VIOLATION;
            end else begin
              r_mid   <= 1'b1;
              r_final <= w_sda_f;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_rx_sda_init_valid = r_init_valid;
  assign o_rx_sda_init       = r_init;
  assign o_rx_sda_mid_change = r_mid;
  assign o_rx_sda_final      = r_final;
  assign o_rx_done           = r_done;
  assign o_violation         = r_violation;

endmodule
`default_nettype wire

// File: doc/i2c_passthru_bitrx.md
I2C_PASSTHRU_BITRX -- requirements
Module: i2c_passthru_bitrx

Interface
REQ-001 Parameter F_REF_T_SU_DAT, default 2: minimum i_f_ref rising edges between an SDA change and the next SCL rise.
REQ-002 Parameter WIDTH_F_REF_SU_DAT, default 2: counter width, CEILING(LOG2(F_REF_T_SU_DAT+1)).
REQ-003 Parameter F_REF_T_SPIKE, default 1: i_f_ref rising edges a raw level must hold before the glitch filter accepts it.
REQ-004 Parameter WIDTH_F_REF_T_SPIKE, default 1: counter width, CEILING(LOG2(F_REF_T_SPIKE+1)).
REQ-005 i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 i_rstn  input  1  reset, asynchronous assert, active-low.
REQ-007 i_f_ref  input  1  timing reference; only its rising edges (detected in i_clk domain) advance timers.
REQ-008 i_scl, i_sda  input  1 each  raw bus pad levels, asynchronous.
REQ-009 i_start_rx  input  1  request to capture one bit period.
REQ-010 o_rx_sda_init_valid  output  1  SDA level at SCL rise is valid.
REQ-011 o_rx_sda_init  output  1  SDA level sampled at SCL rise.
REQ-012 o_rx_sda_mid_change  output  1  SDA toggled while SCL high (START or STOP).
REQ-013 o_rx_sda_final  output  1  SDA level while SCL high, tracked until SCL fall.
REQ-014 o_rx_done  output  1  bit period complete; all rx outputs are stable.
REQ-015 o_violation  output  1  protocol/timing violation detected.

Function
REQ-016 i_scl and i_sda SHALL each pass through a 2-flop synchronizer and then the optional filter (REQ-034), giving scl_f/sda_f.
- Latency pad to scl_f/sda_f: 2 cycles without filter.
REQ-017 FSM states: ST_IDLE, ST_WAIT_LOW, ST_SCL0, ST_SCL1, ST_DONE, ST_VIOLATION; all outputs registered.
REQ-018 ST_IDLE: i_start_rx -> ST_WAIT_LOW; clear init_valid, mid_change, done.
REQ-019 ST_WAIT_LOW: scl_f==0 -> ST_SCL0. A bit period never starts on an already-high SCL.
REQ-020 ST_SCL0: each sda_f change reloads su_timer to F_REF_T_SU_DAT; su_timer decrements once per i_f_ref rising edge and saturates at 0.
REQ-021 ST_SCL0 with scl_f rising: latch o_rx_sda_init=sda_f and o_rx_sda_final=sda_f, set o_rx_sda_init_valid=1, -> ST_SCL1.
- Same edge with su_timer!=0 -> ST_VIOLATION instead.
REQ-022 ST_SCL1: an sda_f change sets o_rx_sda_mid_change=1 and updates o_rx_sda_final=sda_f.
- A second sda_f change within the same SCL-high phase -> ST_VIOLATION.
REQ-023 ST_SCL1 with scl_f falling -> ST_DONE, o_rx_done=1 the following cycle.
- SCL fall and SDA change in the same cycle: the SDA change is ignored; final keeps its prior value.
REQ-024 ST_DONE: outputs hold until i_start_rx.
- On i_start_rx: clear init_valid, mid_change, done; -> ST_WAIT_LOW.
- START = init 1, mid 1, final 0; STOP = init 0, mid 1, final 1.
REQ-025 ST_VIOLATION: o_violation=1, o_rx_done=1.
- On i_start_rx: clear o_violation; -> ST_WAIT_LOW.
REQ-026 i_start_rx in ST_WAIT_LOW, ST_SCL0 or ST_SCL1 SHALL be ignored.
REQ-027 Timer reload has priority over decrement; an i_f_ref edge coincident with an sda_f change reloads only.
REQ-028 Unused/illegal state encodings SHALL go to ST_IDLE next cycle.

Reset
REQ-029 i_rstn low SHALL immediately force ST_IDLE, including in the middle of a bit period.
REQ-030 Reset values: o_rx_sda_init_valid 0, o_rx_sda_init 1, o_rx_sda_mid_change 0, o_rx_sda_final 1, o_rx_done 0, o_violation 0.
REQ-031 Synchronizer and filter flops SHALL reset to 1 (idle bus); su_timer resets to 0; f_ref edge detector resets to 0.
REQ-032 Deassertion SHALL take effect on the next i_clk rising edge; no output toggles between the deassertion and that edge.

Configuration
REQ-033 Macro I2C_PASSTHRU_BITRX_GLITCH_FILTER_EN selects the glitch filter.
REQ-034 With the macro defined: scl_f/sda_f SHALL take a new synchronized level only after it has held for F_REF_T_SPIKE consecutive i_f_ref rising edges; any reversion restarts the count.
REQ-035 Without the macro: scl_f/sda_f SHALL equal the synchronizer outputs, and no filter counters are synthesized.

Verification
REQ-036 Data bit 1: SDA=1 held 5 f_ref periods, SCL low->high->low -> init 1, mid 0, final 1, done=1, violation 0.
REQ-037 START: SCL high, SDA 1->0, then SCL falls -> init 1, mid 1, final 0, done=1.
REQ-038 Setup violation with F_REF_T_SU_DAT=2: SDA toggles 1 f_ref edge before SCL rise -> o_violation=1, o_rx_done=1; i_start_rx clears o_violation.
REQ-039 Double SDA toggle (1->0->1) during SCL high -> o_violation=1.
REQ-040 Filter on, F_REF_T_SPIKE=1: 1-clock SDA low pulse between f_ref edges during SCL high -> mid 0, final 1. Filter off -> o_violation=1.
REQ-041 i_rstn pulsed low in ST_SCL1 -> outputs at REQ-030 values; start with SCL already high -> remains in ST_WAIT_LOW until SCL falls.
